// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system-ID word
// (address 0) and the build timestamp (address 1). It compares both words
// against build-time constants and reports match, mismatch or timeout.
// Optional feature macro: SYSID_CHECKER_RETRY_EN. When it is defined, a
// timed-out read is reissued up to RETRY_MAX times per word before the
// timeout flag is raised.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd1287393522,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1320971153,
`ifdef SYSID_CHECKER_RETRY_EN
    parameter int unsigned RETRY_MAX          = 3,
`endif
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        FINISH
    } state_t;

    // Last counter value at which a capture is still accepted; the counter
    // starts at 0 on the first REQ cycle of every attempt.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic        timeout_reg;
    logic        timeout_next;
    logic        read_reg;
    logic        address_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        in_req;
    logic        in_wait;
    logic        word;
    logic        accept;
    logic        capture;
    logic        timed_out;
    logic        clear;
    logic        retry_ok;
    logic [1:0]  capture_word;

    // Transaction-level decode of the current state and bus handshake.
    // A strobe in a REQ cycle counts only when that cycle is also the
    // accepting one; strobes in IDLE/FINISH are never looked at.
    assign in_req       = (state_reg == REQ_ID) || (state_reg == REQ_TS);
    assign in_wait      = (state_reg == WAIT_ID) || (state_reg == WAIT_TS);
    assign word         = (state_reg == REQ_TS) || (state_reg == WAIT_TS);
    assign accept       = in_req && !avm_waitrequest;
    assign capture      = avm_readdatavalid && (in_wait || accept);
    assign timed_out    = (cnt_reg == TIMEOUT_LAST);
    assign clear        = (state_reg == IDLE) && start;
    assign capture_word = {capture && word, capture && !word};

`ifdef SYSID_CHECKER_RETRY_EN
    localparam int unsigned RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);

    logic [RETRY_W-1:0] retry_reg;
    logic [RETRY_W-1:0] retry_next;

    assign retry_ok = (retry_reg < RETRY_LAST);

    // Retry count for the word currently being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_reg <= '0;
        end else begin
            retry_reg <= retry_next;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // Next-state, timeout counter and timeout flag.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
`ifdef SYSID_CHECKER_RETRY_EN
        retry_next   = retry_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = REQ_ID;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
                    retry_next   = '0;
`endif
                end
            end
            REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
                if (capture) begin
                    // Word done (match or not); move on with a fresh counter.
                    state_next = word ? FINISH : REQ_TS;
                    cnt_next   = '0;
`ifdef SYSID_CHECKER_RETRY_EN
                    retry_next = '0;
`endif
                end else if (timed_out) begin
                    if (retry_ok) begin
                        // Reissue the same word from its REQ state.
                        state_next = word ? REQ_TS : REQ_ID;
                        cnt_next   = '0;
`ifdef SYSID_CHECKER_RETRY_EN
                        retry_next = retry_reg + 1'b1;
`endif
                    end else begin
                        timeout_next = 1'b1;
                        state_next   = FINISH;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                    if (accept) begin
                        state_next = word ? WAIT_TS : WAIT_ID;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered bus/status outputs derived from the
    // state being entered, so they change only on clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
            read_reg    <= 1'b0;
            address_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
            read_reg    <= (state_next == REQ_ID) || (state_next == REQ_TS);
            address_reg <= (state_next == REQ_TS) || (state_next == WAIT_TS);
            busy_reg    <= (state_next == REQ_ID) || (state_next == WAIT_ID) ||
                           (state_next == REQ_TS) || (state_next == WAIT_TS);
            done_reg    <= (state_next == FINISH);
        end
    end

    // Per-word capture: index 0 is the ID word, index 1 the timestamp.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_word
            localparam logic [31:0] EXPECTED = (gi == 0) ? EXPECTED_ID : EXPECTED_TIMESTAMP;

            logic [31:0] value_reg;
            logic        ok_reg;

            // Value is kept across checks; the match flag is cleared on start.
            always_ff @(posedge clk) begin
                if (reset) begin
                    value_reg <= '0;
                    ok_reg    <= 1'b0;
                end else if (clear) begin
                    ok_reg    <= 1'b0;
                end else if (capture_word[gi]) begin
                    value_reg <= avm_readdata;
                    ok_reg    <= (avm_readdata == EXPECTED);
                end
            end
        end
    endgenerate

    assign avm_read    = read_reg;
    assign avm_address = address_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign id_ok       = g_word[0].ok_reg;
    assign ts_ok       = g_word[1].ok_reg;
    assign id_value    = g_word[0].value_reg;
    assign ts_value    = g_word[1].value_reg;

endmodule
